// File: rtl/rgmii_phy_init_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : rgmii_phy_init_ctrl_if
// Brief  : Clause-22 MDIO management bus (MDC, split MDIO data/tristate).
// Rev    : 1.0 - initial release
// ============================================================================
interface rgmii_phy_init_ctrl_if;
    logic mdc;
    logic mdio_o;
    logic mdio_t;
    logic mdio_i;

    modport master (
        output mdc,
        output mdio_o,
        output mdio_t,
        input  mdio_i
    );

    modport slave (
        input  mdc,
        input  mdio_o,
        input  mdio_t,
        output mdio_i
    );
endinterface
`default_nettype wire

// File: rtl/rgmii_phy_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rgmii_phy_init_ctrl
// Brief  : RGMII PHY bring-up: hardware reset, MDIO config writes, BMSR polling.
// Rev    : 1.0 - initial release
// ============================================================================
module rgmii_phy_init_ctrl #(
    parameter int         MDC_DIV       = 25,
    parameter int         RESET_CYCLES  = 1250000,
    parameter int         SETTLE_CYCLES = 6250000,
    parameter int         POLL_CYCLES   = 12500000,
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter int         NUM_CFG       = 2,
    parameter logic [21*((NUM_CFG > 0) ? NUM_CFG : 1)-1:0] CFG_TABLE = '0
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    restart,
    output logic                   phy_reset_n,
    rgmii_phy_init_ctrl_if.master  mdio,
    output logic                   cfg_done,
    output logic                   link_up,
    output logic                   busy
);

    localparam int c_NUM_ENT = (NUM_CFG > 0) ? NUM_CFG : 1;
    localparam int c_MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int c_MAX     = (c_MAX_RS > POLL_CYCLES) ? c_MAX_RS : POLL_CYCLES;
    localparam int c_CNT_W   = (c_MAX > 1) ? $clog2(c_MAX) : 1;
    localparam int c_DIV_W   = $clog2(MDC_DIV);

    localparam logic [c_CNT_W-1:0] c_RST_LAST  = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SET_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_POLL_LAST = c_CNT_W'(POLL_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(MDC_DIV - 1);
    localparam logic [3:0]         c_IDX_LAST  = 4'(NUM_CFG - 1);
    localparam logic [6:0]         c_HALF_LAST = 7'd127;

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_CFG_WR     = 3'd2,
        ST_POLL_RD    = 3'd3,
        ST_POLL_WAIT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_dly_cnt;
    logic [3:0]           r_cfg_idx;
    logic                 r_phy_rst_n;
    logic                 r_cfg_done;
    logic                 r_link_up;
    logic                 r_busy;
    logic                 r_mdc;
    logic                 r_mdio_o;
    logic                 r_mdio_t;
    logic                 r_is_rd;
    logic [c_DIV_W-1:0]   r_div;
    logic [6:0]           r_half;
    logic [63:0]          r_tx;
    logic [15:0]          r_rx;

    logic                 w_cnt_clr;
    logic                 w_start;
    logic                 w_start_rd;
    logic                 w_set_cfg_done;
    logic                 w_idx_inc;
    logic                 w_rst_rel;
    logic                 w_frame_end;
    logic [20:0]          w_entry;
    logic [63:0]          w_frame;
    logic [5:0]           w_next_bit;

    assign w_frame_end = r_busy && (r_div == c_DIV_LAST) && (r_half == c_HALF_LAST);
    assign w_next_bit  = r_half[6:1] + 6'd1;

    always_comb begin
        w_entry = '0;
        for (int i = 0; i < c_NUM_ENT; i++) begin
            if (r_cfg_idx == i[3:0]) begin
                w_entry = CFG_TABLE[21*i +: 21];
            end
        end
    end

    // Read frames carry 1s in the released TA/DATA slots so mdio_o idles high
    assign w_frame = w_start_rd
        ? {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1, 2'b11, 16'hFFFF}
        : {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, w_entry[20:16], 2'b10, w_entry[15:0]};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_clr      = 1'b0;
        w_start        = 1'b0;
        w_start_rd     = 1'b0;
        w_set_cfg_done = 1'b0;
        w_idx_inc      = 1'b0;
        w_rst_rel      = 1'b0;
        case (r_state)
            ST_RST_ASSERT: begin
                if (r_dly_cnt == c_RST_LAST) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_clr   = 1'b1;
                    w_rst_rel   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_dly_cnt == c_SET_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (NUM_CFG == 0) begin
                        w_state_nxt    = ST_POLL_WAIT;
                        w_set_cfg_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_CFG_WR;
                        w_start     = 1'b1;
                    end
                end
            end
            ST_CFG_WR: begin
                w_cnt_clr = 1'b1;
                if (!r_busy) begin
                    w_start = 1'b1;
                end else if (w_frame_end) begin
                    if (r_cfg_idx == c_IDX_LAST) begin
                        w_state_nxt    = ST_POLL_RD;
                        w_set_cfg_done = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            ST_POLL_RD: begin
                w_cnt_clr  = 1'b1;
                w_start_rd = 1'b1;
                if (!r_busy) begin
                    w_start = 1'b1;
                end else if (w_frame_end) begin
                    w_state_nxt = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                w_start_rd = 1'b1;
                if (r_dly_cnt == c_POLL_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_POLL_RD;
                    w_start     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RST_ASSERT;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST_ASSERT;
            r_dly_cnt   <= '0;
            r_cfg_idx   <= '0;
            r_phy_rst_n <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_link_up   <= 1'b0;
            r_busy      <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_t    <= 1'b1;
            r_is_rd     <= 1'b0;
            r_div       <= '0;
            r_half      <= '0;
            r_tx        <= '1;
            r_rx        <= '0;
        end else if (restart) begin
            r_state     <= ST_RST_ASSERT;
            r_dly_cnt   <= '0;
            r_cfg_idx   <= '0;
            r_phy_rst_n <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_link_up   <= 1'b0;
            r_busy      <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_t    <= 1'b1;
            r_is_rd     <= 1'b0;
            r_div       <= '0;
            r_half      <= '0;
            r_tx        <= '1;
            r_rx        <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dly_cnt <= w_cnt_clr ? '0 : r_dly_cnt + 1'b1;
            if (w_rst_rel)      r_phy_rst_n <= 1'b1;
            if (w_set_cfg_done) r_cfg_done  <= 1'b1;
            if (w_idx_inc)      r_cfg_idx   <= r_cfg_idx + 4'd1;

            if (w_start) begin
                r_busy   <= 1'b1;
                r_div    <= '0;
                r_half   <= '0;
                r_mdc    <= 1'b0;
                r_mdio_o <= w_frame[63];
                r_mdio_t <= 1'b0;
                r_tx     <= {w_frame[62:0], 1'b1};
                r_is_rd  <= w_start_rd;
            end else if (r_busy) begin
                if (r_div == c_DIV_LAST) begin
                    r_div <= '0;
                    if (r_half == c_HALF_LAST) begin
                        r_busy   <= 1'b0;
                        r_mdc    <= 1'b0;
                        r_mdio_o <= 1'b1;
                        r_mdio_t <= 1'b1;
                        if (r_is_rd) r_link_up <= r_rx[2];
                    end else begin
                        r_half <= r_half + 7'd1;
                        r_mdc  <= ~r_mdc;
                        // Sample on the rising MDC edge, launch the next bit on the falling edge
                        if (!r_mdc) begin
                            r_rx <= {r_rx[14:0], mdio.mdio_i};
                        end else begin
                            r_mdio_o <= r_tx[63];
                            r_tx     <= {r_tx[62:0], 1'b1};
                            r_mdio_t <= r_is_rd && (w_next_bit >= 6'd46);
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign phy_reset_n = r_phy_rst_n;
    assign cfg_done    = r_cfg_done;
    assign link_up     = r_link_up;
    assign busy        = r_busy;
    assign mdio.mdc    = r_mdc;
    assign mdio.mdio_o = r_mdio_o;
    assign mdio.mdio_t = r_mdio_t;

endmodule
`default_nettype wire
